// File: rtl/bot_trail_map.sv
// Breadcrumb map for RojoBot World: remembers every map cell the bot has occupied
// and returns a per-pixel visited bit to the video colorizer.
module bot_trail_map #(
  parameter int unsigned MAP_BITS = 7,
  parameter int unsigned RESMOD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  LocX,
  input  logic [7:0]  LocY,
  input  logic        UpdSysregs,
  input  logic        TrailEn,
  input  logic        Clear,
  input  logic [9:0]  PixRow,
  input  logic [9:0]  PixCol,
  output logic        TrailPix,
  output logic        Busy,
  output logic [14:0] CrumbCount
);

  localparam int unsigned AW    = 2 * MAP_BITS;
  localparam int unsigned Cells = 2 ** AW;

  typedef enum logic [1:0] {StClear, StIdle, StRd, StWr} state_e;

  state_e          state_q;
  logic [AW-1:0]   clr_addr_q;
  logic [AW-1:0]   rmw_addr_q;
  logic [AW-1:0]   pend_addr_q;
  logic            pend_valid_q;
  logic [14:0]     count_q;

  logic [AW-1:0]   upd_addr;
  logic            loc_ok;
  logic            upd_ok;

  logic            a_we;
  logic            a_wdata;
  logic [AW-1:0]   a_addr;
  logic            a_rdata_q;

  logic [9:0]      vr;
  logic [9:0]      vc;
  logic            vid_ok;
  logic [AW-1:0]   vid_addr_q;
  logic            vid_ok_q;
  logic            vid_ok2_q;
  logic            b_rdata_q;

  logic            mem [Cells];

  // Locations outside the map are dropped before they can reach the pending slot.
  assign loc_ok   = ((LocX >> MAP_BITS) == 8'd0) && ((LocY >> MAP_BITS) == 8'd0);
  assign upd_addr = {LocY[MAP_BITS-1:0], LocX[MAP_BITS-1:0]};
  assign upd_ok   = UpdSysregs && TrailEn && loc_ok;

  always_comb begin
    a_we    = 1'b0;
    a_wdata = 1'b1;
    a_addr  = rmw_addr_q;
    if (rst) begin
      unique case (state_q)
        StClear: begin
          a_we    = 1'b1;
          a_wdata = 1'b0;
          a_addr  = clr_addr_q;
        end
        StWr:    a_we = !Clear;
        default: ;
      endcase
    end
  end

  // Read-first dual-port RAM: port A for the FSM, port B for video.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
    a_rdata_q  <= mem[a_addr];
    b_rdata_q  <= mem[vid_addr_q];
    vid_addr_q <= {vr[MAP_BITS-1:0], vc[MAP_BITS-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StClear;
      clr_addr_q   <= '0;
      rmw_addr_q   <= '0;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      count_q      <= '0;
    end else if (Clear) begin
      state_q      <= StClear;
      clr_addr_q   <= '0;
      pend_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      case (state_q)
        StClear: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (pend_valid_q) begin
            rmw_addr_q   <= pend_addr_q;
            pend_valid_q <= 1'b0;
            state_q      <= StRd;
            if (upd_ok) begin
              pend_addr_q  <= upd_addr;
              pend_valid_q <= 1'b1;
            end
          end else if (upd_ok) begin
            rmw_addr_q <= upd_addr;
            state_q    <= StRd;
          end
        end
        StRd: begin
          if (upd_ok) begin
            pend_addr_q  <= upd_addr;
            pend_valid_q <= 1'b1;
          end
          state_q <= StWr;
        end
        StWr: begin
          if (upd_ok) begin
            pend_addr_q  <= upd_addr;
            pend_valid_q <= 1'b1;
          end
          if (!a_rdata_q && (count_q != 15'(Cells))) begin
            count_q <= count_q + 15'd1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign vr     = PixRow >> RESMOD;
  assign vc     = PixCol >> RESMOD;
  assign vid_ok = ((vr >> MAP_BITS) == 10'd0) && ((vc >> MAP_BITS) == 10'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      vid_ok_q  <= 1'b0;
      vid_ok2_q <= 1'b0;
    end else begin
      vid_ok_q  <= vid_ok;
      vid_ok2_q <= vid_ok_q;
    end
  end

  assign Busy       = (state_q == StClear);
  assign TrailPix   = vid_ok2_q && b_rdata_q && !Busy;
  assign CrumbCount = count_q;

endmodule

// File: tb/tb_bot_trail_map.sv
// Scoreboard bench for bot_trail_map: stimulus pushes timed expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_bot_trail_map;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  LocX = '0;
  logic [7:0]  LocY = '0;
  logic        UpdSysregs = 1'b0;
  logic        TrailEn = 1'b0;
  logic        Clear = 1'b0;
  logic [9:0]  PixRow = '0;
  logic [9:0]  PixCol = '0;
  logic        TrailPix;
  logic        Busy;
  logic [14:0] CrumbCount;

  bot_trail_map #(.MAP_BITS(7), .RESMOD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .LocX       (LocX),
    .LocY       (LocY),
    .UpdSysregs (UpdSysregs),
    .TrailEn    (TrailEn),
    .Clear      (Clear),
    .PixRow     (PixRow),
    .PixCol     (PixCol),
    .TrailPix   (TrailPix),
    .Busy       (Busy),
    .CrumbCount (CrumbCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int KC = 0;  // CrumbCount
  localparam int KT = 1;  // TrailPix
  localparam int KB = 2;  // Busy

  typedef struct {
    int    at;
    int    kind;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model: the set of visited cells and its size.
  bit   vis [16384];
  int   model_count = 0;

  task automatic expect_at(input int at, input int kind, input int exp, input string name);
    exp_t e;
    e.at = at; e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    int act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        act = (sb[i].kind == KC) ? int'(CrumbCount) :
              (sb[i].kind == KT) ? int'(TrailPix) : int'(Busy);
        n_tests++;
        if (act != sb[i].exp) begin
          n_fail++;
          $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                   sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int model_pix(input int row, input int col);
    int vr, vc;
    vr = row >> 2;
    vc = col >> 2;
    if (vr >= 128 || vc >= 128) return 0;
    return int'(vis[vr * 128 + vc]);
  endfunction

  function automatic void record(input int x, input int y);
    if (x < 128 && y < 128 && !vis[y * 128 + x]) begin
      vis[y * 128 + x] = 1'b1;
      model_count++;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16384; i++) vis[i] = 1'b0;
    model_count = 0;
  endfunction

  task automatic pix(input int row, input int col);
    PixRow = 10'(row);
    PixCol = 10'(col);
    expect_at(cyc + 2, KT, model_pix(row, col), $sformatf("trail(r%0d,c%0d)", row, col));
    step();
  endtask

  task automatic upd_raw(input int x, input int y, input bit en);
    LocX = 8'(x);
    LocY = 8'(y);
    TrailEn = en;
    UpdSysregs = 1'b1;
    step();
    UpdSysregs = 1'b0;
  endtask

  // Single update from IDLE; returns once the FSM can accept the next one.
  task automatic upd_model(input int x, input int y, input bit en);
    int n;
    n = cyc;
    upd_raw(x, y, en);
    if (en) record(x, y);
    expect_at(n + 3, KC, model_count, $sformatf("count after (%0d,%0d,en%0d)", x, y, en));
    settle(2);
  endtask

  initial begin
    int r, n, x, y, exp_pix;
    model_clear();

    // Reset and first sweep
    settle(3);
    expect_at(cyc, KB, 1, "busy in reset");
    expect_at(cyc, KC, 0, "count in reset");
    expect_at(cyc, KT, 0, "trail in reset");
    rst = 1'b1;
    r = cyc;
    expect_at(r + 16383, KB, 1, "busy last sweep cycle");
    expect_at(r + 16384, KB, 0, "busy after sweep");
    expect_at(r + 16384, KC, 0, "count after sweep");
    settle(100);
    for (int i = 0; i < 8; i++) pix($urandom_range(0, 511), $urandom_range(0, 511));
    while (cyc < r + 16386) step();
    n_tests++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy direct after first sweep: got %0d, expected 0", Busy);
    end

    // Single update and its pixel footprint
    upd_model(10, 20, 1'b1);
    upd_model(22, 20, 1'b1);
    settle(2);
    for (int rr = 79; rr <= 84; rr++)
      for (int cc = 39; cc <= 44; cc++) pix(rr, cc);
    pix(80, 600);
    pix(600, 40);

    // Repeat location, second pulse lands in RD and is serviced from the pending slot
    LocX = 8'd30; LocY = 8'd31; TrailEn = 1'b1; UpdSysregs = 1'b1;
    n = cyc;
    settle(2);
    UpdSysregs = 1'b0;
    record(30, 31);
    expect_at(n + 3, KC, model_count, "count first of repeat");
    expect_at(n + 6, KC, model_count, "count after pending repeat");
    while (cyc < n + 6) step();
    upd_model(31, 31, 1'b1);

    // Two pulses during one RMW: only the latest is kept
    LocX = 8'd40; LocY = 8'd40; TrailEn = 1'b1; UpdSysregs = 1'b1;
    n = cyc;
    step();
    LocX = 8'd1; LocY = 8'd1;
    step();
    LocX = 8'd2; LocY = 8'd2;
    step();
    UpdSysregs = 1'b0;
    record(40, 40);
    expect_at(n + 3, KC, model_count, "count first rmw");
    expect_at(n + 5, KC, model_count, "count pending not yet written");
    record(2, 2);
    expect_at(n + 6, KC, model_count, "count pending written");
    settle(5);
    pix(4, 4);
    pix(8, 8);
    pix(160, 160);

    // Dropped updates
    upd_model(8'h80, 60, 1'b1);
    upd_model(8'hB2, 50, 1'b1);
    upd_model(5, 8'h85, 1'b1);
    upd_model(60, 60, 1'b0);
    settle(2);
    pix(240, 240);
    pix(200, 200);
    pix(20, 240);

    // Clear during WR
    LocX = 8'd70; LocY = 8'd70; TrailEn = 1'b1; UpdSysregs = 1'b1;
    n = cyc;
    step();
    UpdSysregs = 1'b0;
    step();
    expect_at(n + 2, KC, model_count, "count before clear");
    Clear = 1'b1;
    model_clear();
    expect_at(n + 3, KC, 0, "count after clear");
    expect_at(n + 3, KB, 1, "busy after clear");
    step();
    Clear = 1'b0;
    expect_at(n + 8000, KB, 1, "busy mid clear sweep");
    expect_at(n + 16386, KB, 1, "busy last clear cycle");
    expect_at(n + 16387, KB, 0, "busy after clear sweep");
    settle(50);
    upd_raw(3, 3, 1'b1);
    pix(80, 40);
    pix(12, 12);
    while (cyc < n + 16388) step();
    expect_at(cyc + 2, KC, 0, "count after sweep, update dropped");
    pix(12, 12);
    pix(80, 40);
    pix(80, 88);
    pix(124, 120);
    pix(8, 8);
    pix(160, 160);
    pix(280, 280);

    // Randomized updates, then randomized pixel scan
    for (int i = 0; i < 40; i++) begin
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) x = 128 + $urandom_range(0, 127);
      upd_model(x, y, ($urandom_range(0, 7) != 0));
      settle($urandom_range(0, 2));
    end
    settle(3);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) pix($urandom_range(0, 1023), $urandom_range(0, 1023));
      else pix($urandom_range(0, 67), $urandom_range(0, 67));
    end
    settle(5);

    n_tests++;
    if (int'(CrumbCount) != model_count) begin
      n_fail++;
      $display("FAIL final count direct: got %0d, expected %0d", CrumbCount, model_count);
    end
    n_tests++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL final busy direct: got %0d, expected 0", Busy);
    end
    PixRow = 10'd4;
    PixCol = 10'd4;
    exp_pix = model_pix(4, 4);
    settle(3);
    n_tests++;
    if (int'(TrailPix) != exp_pix) begin
      n_fail++;
      $display("FAIL final trail direct: got %0d, expected %0d", TrailPix, exp_pix);
    end

    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s never checked: got none, expected %0d at cycle %0d",
               sb[0].name, sb[0].exp, sb[0].at);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bot_trail_map.md
# bot_trail_map

Breadcrumb map for RojoBot World. Records every 128x128 world cell the RojoBot has occupied and returns a per-pixel "visited" bit to the video path. Sits beside the world-map pixel source: it consumes bot location updates from the RojoBot CSRs and DTG pixel coordinates, and feeds a trail bit to the colorizer.

## Interface

Parameters:
- MAP_BITS, 7: bits per map coordinate; the map is 2^MAP_BITS x 2^MAP_BITS cells.
- RESMOD, 2: right-shift applied to pixel row/column to get map coordinates.

Ports:
- clk  in  1  system clock, 100 MHz; the only clock.
- rst  in  1  synchronous, active-low reset.
- LocX  in  8  bot X coordinate; same as the RojoBot LocX register.
- LocY  in  8  bot Y coordinate.
- UpdSysregs  in  1  one-cycle pulse; the bot registers have been updated.
- TrailEn  in  1  1 = record locations; 0 = ignore UpdSysregs.
- Clear  in  1  one-cycle pulse; erase the whole map.
- PixRow  in  10  DTG pixel row.
- PixCol  in  10  DTG pixel column.
- TrailPix  out  1  1 = the cell under the current pixel has been visited.
- Busy  out  1  1 = a clear sweep is in progress.
- CrumbCount  out  15  number of distinct visited cells, range 0..16384.

## Operation

- Storage is a dual-port 2^(2*MAP_BITS) x 1 bit RAM. Address = {row, col}, with row = Y and col = X.
- Port A is owned by the FSM and used for clear and read-modify-write (RMW).
- Port B is read-only and serves video.

FSM states:
- CLEAR:
  - Writes 0 to the address in clr_addr, then increments clr_addr, one address per cycle.
  - After writing the last address (all ones), go to IDLE.
- IDLE:
  - If a pending update is valid, load it into the RMW address and go to RD.
  - Otherwise, on UpdSysregs=1 with TrailEn=1, capture LocY/LocX and go to RD.
  - If LocX[7] or LocY[7] is set (only when MAP_BITS=7), the update is dropped and the state stays IDLE.
- RD: read the addressed bit on port A, then go to WR.
- WR:
  - Write 1 to the address.
  - If the bit read in RD was 0, increment CrumbCount.
  - Go to IDLE.

Update and clear rules:
- An UpdSysregs pulse (with TrailEn=1) arriving in RD or WR goes into a one-deep pending slot; the latest pulse overwrites the slot.
- UpdSysregs arriving in CLEAR is dropped.
- A Clear pulse in any state does all of the following:
  - enters CLEAR with clr_addr=0;
  - drops the pending slot;
  - sets CrumbCount to 0 on the next cycle;
  - abandons any RMW in flight, with no write.
- A Clear pulse during CLEAR restarts the sweep at 0.
- Clear and UpdSysregs in the same cycle: Clear wins and the update is dropped.

Video read path:
- vr = PixRow >> RESMOD and vc = PixCol >> RESMOD.
- If vr or vc is >= 2^MAP_BITS, the result is 0 (the region outside the map).
- Otherwise the result is the RAM bit at {vr[MAP_BITS-1:0], vc[MAP_BITS-1:0]}.
- TrailPix is forced to 0 while Busy=1.
- CrumbCount saturates at 2^(2*MAP_BITS) and never wraps.

## Timing

Reset:
- While rst=0: state=CLEAR, clr_addr=0, pending slot empty, TrailPix=0, CrumbCount=0, Busy=1.
- The sweep starts on the first cycle with rst=1.
- The sweep lasts 2^(2*MAP_BITS) cycles (16384 with the default).
- Busy falls in the cycle after the last address is written.
- Reasserting rst mid-sweep restarts the sweep.

Latencies:
- Video read: PixRow/PixCol sampled at edge N produce TrailPix valid after edge N+2 (address register, then RAM/output register). The path is fully pipelined, one pixel per clk.
- RMW from IDLE: UpdSysregs at edge N -> RD at N+1 -> WR at N+2 -> the bit is written and CrumbCount is updated after edge N+3.
- Video sees a newly written bit 2 cycles after the write.
- Simultaneous port A write and port B read of the same address returns the old value (read-first).
- Pending update: serviced immediately after WR, so it finishes 3 cycles after the prior one.

## Test plan

- Reset, then release rst: Busy=1 for exactly 16384 cycles, then 0; CrumbCount=0; TrailPix=0 throughout.
- TrailEn=1, UpdSysregs with LocX=10, LocY=20: CrumbCount=1 three cycles later. Driving PixRow=80..83 and PixCol=40..43 gives TrailPix=1 two cycles later; PixCol=44 gives 0.
- Same location updated twice, then location (11,20): CrumbCount ends at 2. Second pulse sent in the RD cycle is serviced from the pending slot.
- Two pulses during one RMW, (1,1) then (2,2): only (2,2) is recorded; CrumbCount=2 total.
- LocX=0x80 update is dropped (count unchanged). PixCol=600 gives TrailPix=0. TrailEn=0 update is ignored.
- Clear asserted in the WR cycle of an RMW: no write, CrumbCount=0 next cycle, Busy=1 for 16384 cycles. UpdSysregs during the sweep is dropped, and the map reads all zeros afterwards.
